// File: rtl/fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter
//
// Purpose:
//   Shares one FIFO enqueue port among NUM_REQ_P requesters. Ownership rotates
//   round-robin. An owner keeps the port for up to BURST_P accepted words, or
//   until it drops its valid. The arbiter then spends one IDLE cycle and
//   searches again, starting at the requester after the last owner.
//
// Parameters:
//   NUM_REQ_P  number of requesters (default 4)
//   WIDTH_P    word width (default 8)
//   BURST_P    maximum words per grant, 1..16 (default 4)
//
// Ports:
//   clk_i        sole clock, all state on posedge
//   reset_n_i    asynchronous active-low reset
//   req_valid_i  per-requester word valid
//   req_data_i   per-requester word, requester k at [k*WIDTH_P +: WIDTH_P]
//   req_ready_o  per-requester accept (only the owner's bit can be set)
//   valid_o      word valid toward FIFO valid_i
//   data_o       word toward FIFO data_i
//   ready_i      FIFO ready_o
//   grant_o      one-hot current owner, all-zero when idle
//   grant_cnt_o  (only with FIFO_ARB_GRANT_CNT_EN) per-requester saturating
//                16-bit transfer counts, requester k at [k*16 +: 16]
//
// Build option:
//   FIFO_ARB_GRANT_CNT_EN  when defined, adds grant_cnt_o and its counters.
//
// States:
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | no owner; outputs quiet; pick next owner from req_valid_i
//   ST_GRANTED | r_owner drives the FIFO port; r_beat counts accepted words
// -----------------------------------------------------------------------------
module fifo_rr_arbiter #(
  parameter int NUM_REQ_P = 4,
  parameter int WIDTH_P   = 8,
  parameter int BURST_P   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [NUM_REQ_P-1:0]         req_valid_i,
  input  logic [NUM_REQ_P*WIDTH_P-1:0] req_data_i,
  output logic [NUM_REQ_P-1:0]         req_ready_o,
  output logic                         valid_o,
  output logic [WIDTH_P-1:0]           data_o,
  input  logic                         ready_i,
  output logic [NUM_REQ_P-1:0]         grant_o
`ifdef FIFO_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ_P*16-1:0]      grant_cnt_o
`endif
);

  localparam int               IDX_W     = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;
  localparam logic [3:0]       LAST_BEAT = 4'(BURST_P - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ_P - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_owner_nxt;
  logic [IDX_W-1:0] r_last_owner;
  logic [IDX_W-1:0] w_last_owner_nxt;
  logic [3:0]       r_beat;
  logic [3:0]       w_beat_nxt;

  logic [IDX_W-1:0] w_search_idx;
  logic             w_found;
  logic             w_owner_valid;
  logic             w_xfer;
  logic [WIDTH_P-1:0] w_req_data [NUM_REQ_P];

  // Unpack the flat data bus so the owner's word is a simple array select.
  always_comb begin
    for (int k = 0; k < NUM_REQ_P; k++) begin
      w_req_data[k] = req_data_i[k*WIDTH_P +: WIDTH_P];
    end
  end

  // Round-robin search: first set request at last_owner+1, +2, ... wrapping,
  // so the last owner itself is tried last.
  always_comb begin : p_search
    int v_idx;
    v_idx        = 0;
    w_found      = 1'b0;
    w_search_idx = r_last_owner;
    for (int i = 1; i <= NUM_REQ_P; i++) begin
      v_idx = (int'(r_last_owner) + i) % NUM_REQ_P;
      if (!w_found && req_valid_i[v_idx]) begin
        w_found      = 1'b1;
        w_search_idx = IDX_W'(v_idx);
      end
    end
  end

  assign w_owner_valid = req_valid_i[r_owner];

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= LAST_IDX;
      r_beat       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_beat       <= w_beat_nxt;
    end
  end

  // Next state and outputs. Outputs decode from r_state only, so the
  // asynchronous reset silences them in the same cycle it is asserted.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_beat_nxt       = r_beat;
    valid_o          = 1'b0;
    data_o           = '0;
    req_ready_o      = '0;
    grant_o          = '0;
    w_xfer           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANTED;
          w_owner_nxt = w_search_idx;
        end
      end

      ST_GRANTED: begin
        valid_o              = w_owner_valid;
        data_o               = w_req_data[r_owner];
        req_ready_o[r_owner] = ready_i;
        grant_o[r_owner]     = 1'b1;
        w_xfer               = w_owner_valid && ready_i;

        // Release on the last word of a burst, or when the owner runs dry.
        // A stalled FIFO (ready_i low) simply holds everything.
        if (!w_owner_valid || (w_xfer && (r_beat == LAST_BEAT))) begin
          w_state_nxt      = ST_IDLE;
          w_last_owner_nxt = r_owner;
          w_beat_nxt       = '0;
        end else if (w_xfer) begin
          w_beat_nxt = r_beat + 4'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef FIFO_ARB_GRANT_CNT_EN
  logic [15:0] r_grant_cnt [NUM_REQ_P];

  // Counts accepted words per requester; sticks at all-ones.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NUM_REQ_P; k++) begin
        r_grant_cnt[k] <= '0;
      end
    end else if (w_xfer && (r_grant_cnt[r_owner] != 16'hFFFF)) begin
      r_grant_cnt[r_owner] <= r_grant_cnt[r_owner] + 16'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ_P; k++) begin
      grant_cnt_o[k*16 +: 16] = r_grant_cnt[k];
    end
  end
`else
  // No transfer counters in this build; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   tb_valid;
  logic [N*W-1:0] tb_data;
  logic           tb_ready;
  logic [N-1:0]   req_ready;
  logic           valid_out;
  logic [W-1:0]   data_out;
  logic [N-1:0]   grant;
`ifdef FIFO_ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  fifo_rr_arbiter #(.NUM_REQ_P(N), .WIDTH_P(W), .BURST_P(B)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .req_valid_i (tb_valid),
    .req_data_i  (tb_data),
    .req_ready_o (req_ready),
    .valid_o     (valid_out),
    .data_o      (data_out),
    .ready_i     (tb_ready),
    .grant_o     (grant)
`ifdef FIFO_ARB_GRANT_CNT_EN
    ,
    .grant_cnt_o (grant_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, who owned it last, words served in
  // the current grant, and which requester (if any) had a word taken at the
  // most recent edge.
  int m_owner;
  int m_last;
  int m_served;
  int m_acc;

  logic       pend  [N];
  logic [W-1:0] pdata [N];

  typedef struct {
    logic [N-1:0] valid;
    logic         ready;
    logic [N-1:0] exp_grant;
    logic         exp_valid;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_owner  = -1;
    m_last   = N - 1;
    m_served = 0;
    m_acc    = -1;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit found;
    m_acc = -1;
    if (m_owner < 0) begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        if (!found && tb_valid[(m_last + i) % N]) begin
          found   = 1;
          m_owner = (m_last + i) % N;
        end
      end
    end else if (!tb_valid[m_owner]) begin
      m_last   = m_owner;
      m_owner  = -1;
      m_served = 0;
    end else if (tb_ready) begin
      m_acc = m_owner;
      m_served++;
      if (m_served == B) begin
        m_last   = m_owner;
        m_owner  = -1;
        m_served = 0;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic         ev;
    eg = '0;
    er = '0;
    ev = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ev          = tb_valid[m_owner];
      er[m_owner] = tb_ready;
    end
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".valid"}, 32'(valid_out), 32'(ev));
    check({tag, ".ready"}, 32'(req_ready), 32'(er));
    if (ev) check({tag, ".data"}, 32'(data_out), 32'(tb_data[m_owner*W +: W]));
  endtask

  // One clock: compare at negedge, update model at posedge, leave inputs
  // free to change 1 time unit after the edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    compare_model(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".valid"}, 32'(valid_out), 32'd0);
    check({tag, ".grant"}, 32'(grant), 32'd0);
    check({tag, ".ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    tb_valid = '0;
    tb_ready = 1'b0;
    #1;
    check_quiet("rst_assert");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_quiet("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_random();
    for (int k = 0; k < N; k++) begin
      if (pend[k] && m_acc == k) pend[k] = 1'b0;
      if (!pend[k] && $urandom_range(0, 2) == 0) begin
        pend[k]  = 1'b1;
        pdata[k] = W'($urandom);
      end
      tb_valid[k]          = pend[k];
      tb_data[k*W +: W]    = pdata[k];
    end
    tb_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int c;
    int cnt;
    logic [N-1:0] g32 [6];
    logic         v32 [6];

    // Only requester 2 with 8'hA5: stall 3 cycles, then a full burst, one
    // idle, a new grant, then the owner drops valid.
    vecs[0]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000};
    vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000};
    vecs[3]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000};
    vecs[4]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100};
    vecs[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100};
    vecs[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100};
    vecs[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100};
    vecs[8]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0000};
    vecs[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100};
    vecs[10] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};

    rst_n    = 1'b1;
    tb_valid = '0;
    tb_ready = 1'b0;
    tb_data  = '0;
    for (int k = 0; k < N; k++) begin
      pend[k]  = 1'b0;
      pdata[k] = '0;
    end
    reset_model();

    // Reset with no requests: quiet every cycle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tb_ready = 1'(i % 2);
      cycle("idle");
      check_quiet("idle_explicit");
    end

    // Table: single requester, stall, burst, drop.
    do_reset();
    tb_data = 32'h00A5_0000;
    for (int i = 0; i < 12; i++) begin
      tb_valid = vecs[i].valid;
      tb_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d.valid", i), 32'(valid_out), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_valid) check($sformatf("vec%0d.data", i), 32'(data_out), 32'h0000_00A5);
      @(posedge clk);
      model_step();
      #1;
    end

    // All requesting, FIFO always ready: 4-word bursts rotating 0..3, idle between.
    do_reset();
    tb_valid = 4'b1111;
    tb_ready = 1'b1;
    tb_data  = 32'h4433_2211;
    for (int i = 0; i < 25; i++) begin
      logic [N-1:0] eg;
      eg = '0;
      if (i % 5 != 0) eg[(i / 5) % N] = 1'b1;
      @(negedge clk);
      check("burst_seq", 32'(grant), 32'(eg));
      compare_model("burst");
      @(posedge clk);
      model_step();
      #1;
    end

    // Owner 1 drops valid after two words while requester 3 waits.
    do_reset();
    g32[0] = 4'b0000; v32[0] = 1'b0;
    g32[1] = 4'b0010; v32[1] = 1'b1;
    g32[2] = 4'b0010; v32[2] = 1'b1;
    g32[3] = 4'b0010; v32[3] = 1'b0;
    g32[4] = 4'b0000; v32[4] = 1'b0;
    g32[5] = 4'b1000; v32[5] = 1'b1;
    tb_valid = 4'b1010;
    tb_ready = 1'b1;
    tb_data  = 32'h3300_1100;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) tb_valid = 4'b1000;
      @(negedge clk);
      check($sformatf("drop%0d.grant", i), 32'(grant), 32'(g32[i]));
      check($sformatf("drop%0d.valid", i), 32'(valid_out), 32'(v32[i]));
      @(posedge clk);
      model_step();
      #1;
    end

    // Reset at beat 2 of requester 1's burst; afterwards requester 0 wins.
    do_reset();
    tb_valid = 4'b0110;
    tb_ready = 1'b1;
    tb_data  = 32'h0022_1100;
    for (int i = 0; i < 3; i++) cycle("pre_rst");
    check("midrst.pre_grant", 32'(grant), 32'b0010);
    tb_valid = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("midrst.same_cycle");
    @(posedge clk);
    #1;
    check_quiet("midrst.held");
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    #1;
    check_quiet("midrst.release");
    @(posedge clk);
    model_step();
    #1;
    check("midrst.first_grant", 32'(grant), 32'b0001);
    check("midrst.first_valid", 32'(valid_out), 32'd1);

`ifdef FIFO_ARB_GRANT_CNT_EN
    // Ten words from requester 3 only.
    do_reset();
    tb_valid = 4'b1000;
    tb_ready = 1'b1;
    tb_data  = 32'h5A00_0000;
    cnt = 0;
    c   = 0;
    while (cnt < 10 && c < 60) begin
      @(negedge clk);
      compare_model("cnt");
      @(posedge clk);
      model_step();
      if (m_acc == 3) cnt++;
      #1;
      if (cnt == 10) tb_valid = '0;
      c++;
    end
    check("cnt.reached", 32'(cnt), 32'd10);
    repeat (2) @(negedge clk);
    check("cnt.req3", 32'(grant_cnt[63:48]), 32'd10);
    check("cnt.others", 32'(grant_cnt[47:0] != 48'd0), 32'd0);
    @(posedge clk);
    #1;
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
